// File: rtl/shift_pipe_param_if.sv
// Bundle of control, data and status signals around shift_pipe_param.
// The master side drives controls/data in; the slave side is the pipe itself.
interface shift_pipe_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                     en;
   logic [1:0]               mode;
   logic                     flush;
   logic [WIDTH-1:0]         din;
   logic                     din_valid;
   logic [WIDTH*DEPTH-1:0]   load_data;
   logic [WIDTH-1:0]         dout;
   logic                     dout_valid;
   logic [WIDTH*DEPTH-1:0]   taps;
   logic [DEPTH-1:0]         tap_valid;
   logic [CW-1:0]            fill_cnt;
   logic                     full;

   modport master (
      output en, mode, flush, din, din_valid, load_data,
      input  dout, dout_valid, taps, tap_valid, fill_cnt, full
   );

   modport slave (
      input  en, mode, flush, din, din_valid, load_data,
      output dout, dout_valid, taps, tap_valid, fill_cnt, full
   );
endinterface

// File: rtl/shift_pipe_param.sv
// Parametrised shift/rotate/load pipeline with per-stage valids and a running fill count.
// Stage 0 is the input end, stage DEPTH-1 drives dout.
module shift_pipe_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shift_pipe_param_if.slave    bus
);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_SHIFT  = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

   logic [DEPTH-1:0][WIDTH-1:0] r_data;
   logic [DEPTH-1:0]            r_valid;
   logic [CW-1:0]               r_fill;

   logic [DEPTH-1:0][WIDTH-1:0] w_data_next;
   logic [DEPTH-1:0]            w_valid_next;
   logic [CW-1:0]               w_fill_next;

   logic [DEPTH-1:0][WIDTH-1:0] w_shift_data;
   logic [DEPTH-1:0]            w_shift_valid;
   logic [DEPTH-1:0][WIDTH-1:0] w_rot_data;
   logic [DEPTH-1:0]            w_rot_valid;
   logic [DEPTH-1:0][WIDTH-1:0] w_load_data;
   logic [CW-1:0]               w_fill_shift;

   assign w_load_data = bus.load_data;

   // Candidate next images for shift and rotate, built stage by stage from pre-edge values.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign w_shift_data[gi]  = bus.din;
            assign w_shift_valid[gi] = bus.din_valid;
            assign w_rot_data[gi]    = r_data[DEPTH-1];
            assign w_rot_valid[gi]   = r_valid[DEPTH-1];
         end else begin : g_body
            assign w_shift_data[gi]  = r_data[gi-1];
            assign w_shift_valid[gi] = r_valid[gi-1];
            assign w_rot_data[gi]    = r_data[gi-1];
            assign w_rot_valid[gi]   = r_valid[gi-1];
         end
      end
   endgenerate

   // Incoming valid in, outgoing valid out: stays within 0..DEPTH by construction.
   assign w_fill_shift = r_fill + CW'(bus.din_valid) - CW'(r_valid[DEPTH-1]);

   always_comb begin
      w_data_next  = r_data;
      w_valid_next = r_valid;
      w_fill_next  = r_fill;
      if (bus.flush) begin
         w_data_next  = '0;
         w_valid_next = '0;
         w_fill_next  = '0;
      end else if (bus.en) begin
         case (bus.mode)
            MODE_SHIFT: begin
               w_data_next  = w_shift_data;
               w_valid_next = w_shift_valid;
               w_fill_next  = w_fill_shift;
            end
            MODE_ROTATE: begin
               w_data_next  = w_rot_data;
               w_valid_next = w_rot_valid;
            end
            MODE_LOAD: begin
               w_data_next  = w_load_data;
               w_valid_next = '1;
               w_fill_next  = CW'(DEPTH);
            end
            MODE_HOLD: begin
               w_data_next  = r_data;
            end
            default: begin
               w_data_next  = r_data;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= '0;
         r_fill  <= '0;
      end else begin
         r_data  <= w_data_next;
         r_valid <= w_valid_next;
         r_fill  <= w_fill_next;
      end
   end

   assign bus.dout       = r_data[DEPTH-1];
   assign bus.dout_valid = r_valid[DEPTH-1];
   assign bus.taps       = r_data;
   assign bus.tap_valid  = r_valid;
   assign bus.fill_cnt   = r_fill;
   assign bus.full       = (r_fill == CW'(DEPTH));
endmodule

// File: doc/shift_pipe_param.md
# shift_pipe_param

Parametrised, resettable multi-stage shift register that generalises the team's fixed three-flop data pipeline. It offers configurable data width and depth, per-stage valid tracking, rotate and parallel-load modes, and synchronous flush. It sits between a data source and a downstream consumer as a programmable delay line or a serial/parallel converter.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 3, number of stages (≥1); stage 0 is the input end, stage DEPTH-1 the output end
- CW, $clog2(DEPTH+1), width of fill_cnt (derived, not overridden)

- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  stage advance enable; when 0, all state holds
- mode  input  2  00 hold, 01 shift, 10 rotate, 11 parallel load
- flush  input  1  synchronous clear of all stages; priority over en/mode
- din  input  WIDTH  serial data into stage 0 (shift mode)
- din_valid  input  1  valid qualifier for din
- load_data  input  WIDTH*DEPTH  parallel load image; bits [WIDTH*i +: WIDTH] go to stage i
- dout  output  WIDTH  contents of stage DEPTH-1
- dout_valid  output  1  valid bit of stage DEPTH-1
- taps  output  WIDTH*DEPTH  all stage contents, same packing as load_data
- tap_valid  output  DEPTH  per-stage valid bits
- fill_cnt  output  CW  number of stages with valid set
- full  output  1  fill_cnt == DEPTH

## Operation
- Every stage is a true register updated with non-blocking semantics. All stages update simultaneously from pre-edge values, and no stage ever takes its neighbour's new value in the same edge.
- Priority at each rising edge: flush > (en==0) > mode.
- flush=1: all data stages become 0, all valids become 0, and fill_cnt becomes 0, regardless of en and mode.
- en=0 (no flush): no state changes.
- mode 00 hold: no state changes.
- mode 01 shift: stage0 ← din, valid0 ← din_valid; stage i ← stage i-1 and valid i ← valid i-1 for i≥1. The old stage DEPTH-1 content is discarded.
- mode 10 rotate: stage0 ← stage DEPTH-1; stage i ← stage i-1. Valids rotate identically, so fill_cnt is unchanged. With DEPTH=1, rotate is equivalent to hold.
- mode 11 load: stage i ← load_data slice i, all valids ← 1, fill_cnt ← DEPTH.
- fill_cnt is maintained incrementally and must always equal the popcount of tap_valid.
  - In shift mode it changes by (din_valid − old valid of stage DEPTH-1), giving +1, 0 or −1.
  - It never exceeds DEPTH and never underflows.
- full is combinational from fill_cnt.
- All outputs are direct register outputs or simple decodes of registers; there is no combinational path from any input to any output.

## Timing
- Reset (rst_n=0, asynchronous assert): all stages 0, all valids 0, fill_cnt 0, full 0, dout 0, dout_valid 0.
  - Reset release is synchronous to the next rising edge.
  - Reset asserted mid-operation discards all contents immediately, without waiting for clk.
- Shift latency: din sampled at edge k appears on dout at edge k+DEPTH-1, i.e. after DEPTH consecutive enabled shift edges.
- Cycles with en=0 or mode=00 stretch the latency one-for-one with no data loss.
- Load takes effect on the edge it is sampled: taps equal load_data and full=1 one edge later.
- Flush takes effect on the same edge. A din presented alongside flush is dropped.
- A mode change between consecutive edges is legal; each edge applies only the mode sampled at that edge.
- Boundary: shift with din_valid=1 while full=1 keeps fill_cnt at DEPTH. The outgoing valid word is presented on dout in the cycle before that edge, and the consumer must take it then.
- Boundary: shift with din_valid=0 while empty keeps fill_cnt at 0.

## Test plan
- Reset: hold rst_n=0 with random inputs toggling → all outputs 0. Assert rst_n low asynchronously between edges while the pipe is full → outputs 0 immediately.
- Fill/latency (WIDTH=8, DEPTH=3): shift 0x11, 0x22, 0x33, each with valid=1 → after 3rd edge dout=0x11, taps={0x33,0x22,0x11}, fill_cnt=3, full=1.
  - A 4th shift of 0x44 → dout=0x22, fill_cnt=3.
- Bubbles and stalls: alternate din_valid 1/0 with en dropped for 2 cycles mid-stream → dout order is preserved, latency stretches by exactly 2, and fill_cnt always equals popcount(tap_valid).
- Rotate: load {0xA0,0xB1,0xC2} then rotate 3 edges → contents return to the original image; after 1 rotate, stage0=0xC2; fill_cnt stays 3 throughout.
- Flush priority: full pipe, assert flush with mode=11 and en=1 in the same cycle → all taps 0, tap_valid=0, fill_cnt=0. Load resumes on the next edge.
- Parameter sweep: DEPTH=1 and DEPTH=8 with WIDTH=1 and WIDTH=32, run against a reference queue model with random mode/en/flush → no mismatch over 10k cycles.
